// File: rtl/scope_trigger_capture_pkg.sv
// Shared widths, defaults and FSM encoding for the scope trigger/capture block.
// Pure declarations: no logic, no latency, no flow control.
package scope_trigger_capture_pkg;

    localparam int DW_DEF           = 12;
    localparam int NCH_DEF          = 8;
    localparam int AW_DEF           = 9;
    localparam int AUTO_TIMEOUT_DEF = 4096;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT,
        POST,
        DONE
    } state_t;

endpackage

// File: rtl/scope_trigger_capture_if.sv
// Sample-stream and readout bundle between the ADC front end / display and the capture block.
// Wires only; the strobes carry no backpressure.
interface scope_trigger_capture_if
    import scope_trigger_capture_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int NCH = NCH_DEF,
    parameter int AW  = AW_DEF
);
    logic [NCH*DW-1:0] ch_data;
    logic [NCH-1:0]    ch_vld;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_data;

    modport master (output ch_data, ch_vld, rd_addr, input rd_data);
    modport slave  (input ch_data, ch_vld, rd_addr, output rd_data);
endinterface

// File: rtl/scope_sample_ram.sv
// Simple dual-port frame store: one write port, registered read port (1-cycle latency).
// No backpressure; a same-address read during a write returns the old word.
module scope_sample_ram #(
    parameter int DW = 12,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_dat_q, rd_dat_d;

    always_comb rd_dat_d = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_dat_q <= '0;
        else        rd_dat_q <= rd_dat_d;
    end

    assign rd_dat = rd_dat_q;
endmodule

// File: rtl/scope_trigger_capture.sv
// Scope capture: channel select, decimation, level/edge trigger with auto timeout, circular frame buffer.
// Status is registered (1 cycle after the deciding sample); strobes are never stalled, unselected/decimated ones are dropped.
module scope_trigger_capture
    import scope_trigger_capture_pkg::*;
#(
    parameter int DW           = DW_DEF,
    parameter int NCH          = NCH_DEF,
    parameter int AW           = AW_DEF,
    parameter int AUTO_TIMEOUT = AUTO_TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    scope_trigger_capture_if.slave bus,
    input  logic [$clog2(NCH)-1:0] ch_sel,
    input  logic [DW-1:0]          trig_level,
    input  logic                   trig_edge,
    input  logic                   trig_auto,
    input  logic [7:0]             decim,
    input  logic [AW-1:0]          pre_len,
    input  logic                   arm,
    output logic                   busy,
    output logic                   frame_ready,
    output logic                   triggered,
    output logic [AW-1:0]          trig_addr,
    output logic [AW-1:0]          frame_start
);
    localparam int SW    = $clog2(NCH);
    localparam int TW    = $clog2(AUTO_TIMEOUT);
    localparam int DEPTH = 1 << AW;

    state_t        state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [DW-1:0] level_q, level_d;
    logic          edge_q, edge_d;
    logic          auto_q, auto_d;
    logic [7:0]    decim_q, decim_d;
    logic [AW-1:0] pre_len_q, pre_len_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [7:0]    dec_cnt_q, dec_cnt_d;
    logic [AW-1:0] pre_cnt_q, pre_cnt_d;
    logic [AW:0]   post_cnt_q, post_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          prev_valid_q, prev_valid_d;
    logic [DW-1:0] prev_q, prev_d;
    logic [AW-1:0] trig_addr_q, trig_addr_d;
    logic [AW-1:0] frame_start_q, frame_start_d;
    logic          triggered_q, triggered_d;
    logic          busy_q, busy_d;
    logic          frame_ready_q, frame_ready_d;

    logic [DW-1:0] cur_smp;
    logic          sel_vld, acc, wr_en, hit_edge, hit_auto, do_trig;
    logic [AW:0]   post_target;

    always_comb begin
        cur_smp     = bus.ch_data[int'(sel_q)*DW +: DW];
        sel_vld     = bus.ch_vld[sel_q];
        acc         = sel_vld && (dec_cnt_q == '0) && !arm;
        wr_en       = acc && (state_q inside {PRE, WAIT, POST});
        if (edge_q == EDGE_RISE) hit_edge = prev_valid_q && (prev_q < level_q) && (cur_smp >= level_q);
        else                     hit_edge = prev_valid_q && (prev_q > level_q) && (cur_smp <= level_q);
        hit_auto    = auto_q && (tmo_cnt_q == TW'(AUTO_TIMEOUT - 1));
        do_trig     = wr_en && (state_q == WAIT) && (hit_edge || hit_auto);
        // Post count includes the trigger sample, so pre + post always fills the buffer exactly.
        post_target = (AW+1)'(DEPTH) - {1'b0, pre_len_q};

        state_d       = state_q;
        sel_d         = sel_q;
        level_d       = level_q;
        edge_d        = edge_q;
        auto_d        = auto_q;
        decim_d       = decim_q;
        pre_len_d     = pre_len_q;
        wr_ptr_d      = wr_ptr_q;
        dec_cnt_d     = dec_cnt_q;
        pre_cnt_d     = pre_cnt_q;
        post_cnt_d    = post_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        prev_valid_d  = prev_valid_q;
        prev_d        = prev_q;
        trig_addr_d   = trig_addr_q;
        frame_start_d = frame_start_q;
        triggered_d   = triggered_q;

        if (sel_vld) dec_cnt_d = (dec_cnt_q == decim_q) ? 8'd0 : dec_cnt_q + 8'd1;

        if (wr_en) begin
            wr_ptr_d     = wr_ptr_q + AW'(1);
            prev_d       = cur_smp;
            prev_valid_d = 1'b1;
        end

        case (state_q)
            PRE: begin
                if (wr_en) begin
                    pre_cnt_d = pre_cnt_q + AW'(1);
                    if (pre_cnt_q + AW'(1) == pre_len_q) state_d = WAIT;
                end
            end
            WAIT: begin
                if (wr_en) tmo_cnt_d = tmo_cnt_q + TW'(1);
                if (do_trig) begin
                    triggered_d   = hit_edge;
                    trig_addr_d   = wr_ptr_q;
                    frame_start_d = wr_ptr_q - pre_len_q;
                    post_cnt_d    = (AW+1)'(1);
                    state_d       = (post_target == (AW+1)'(1)) ? DONE : POST;
                end
            end
            POST: begin
                if (wr_en) begin
                    post_cnt_d = post_cnt_q + (AW+1)'(1);
                    if (post_cnt_q + (AW+1)'(1) == post_target) state_d = DONE;
                end
            end
            default: ;
        endcase

        // Arm overrides any sample/trigger decision made in the same cycle.
        if (arm) begin
            sel_d        = ch_sel;
            level_d      = trig_level;
            edge_d       = trig_edge;
            auto_d       = trig_auto;
            decim_d      = decim;
            pre_len_d    = pre_len;
            wr_ptr_d     = '0;
            dec_cnt_d    = '0;
            pre_cnt_d    = '0;
            post_cnt_d   = '0;
            tmo_cnt_d    = '0;
            prev_valid_d = 1'b0;
            state_d      = (pre_len == '0) ? WAIT : PRE;
        end

        busy_d        = state_d inside {PRE, WAIT, POST};
        frame_ready_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            level_q       <= '0;
            edge_q        <= 1'b0;
            auto_q        <= 1'b0;
            decim_q       <= '0;
            pre_len_q     <= '0;
            wr_ptr_q      <= '0;
            dec_cnt_q     <= '0;
            pre_cnt_q     <= '0;
            post_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
            prev_valid_q  <= 1'b0;
            prev_q        <= '0;
            trig_addr_q   <= '0;
            frame_start_q <= '0;
            triggered_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            level_q       <= level_d;
            edge_q        <= edge_d;
            auto_q        <= auto_d;
            decim_q       <= decim_d;
            pre_len_q     <= pre_len_d;
            wr_ptr_q      <= wr_ptr_d;
            dec_cnt_q     <= dec_cnt_d;
            pre_cnt_q     <= pre_cnt_d;
            post_cnt_q    <= post_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            prev_valid_q  <= prev_valid_d;
            prev_q        <= prev_d;
            trig_addr_q   <= trig_addr_d;
            frame_start_q <= frame_start_d;
            triggered_q   <= triggered_d;
            busy_q        <= busy_d;
            frame_ready_q <= frame_ready_d;
        end
    end

    scope_sample_ram #(.DW(DW), .AW(AW)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_dat  (cur_smp),
        .rd_addr (bus.rd_addr),
        .rd_dat  (bus.rd_data)
    );

    assign busy        = busy_q;
    assign frame_ready = frame_ready_q;
    assign triggered   = triggered_q;
    assign trig_addr   = trig_addr_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_scope_trigger_capture.sv
// Directed bench for scope_trigger_capture: each scenario task drives strobes and checks hand-computed results.
module tb_scope_trigger_capture;
    import scope_trigger_capture_pkg::*;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic [2:0]  ch_sel     = '0;
    logic [11:0] trig_level = '0;
    logic        trig_edge  = 1'b0;
    logic        trig_auto  = 1'b0;
    logic [7:0]  decim      = '0;
    logic [8:0]  pre_len    = '0;
    logic        arm        = 1'b0;
    logic        busy, frame_ready, triggered;
    logic [8:0]  trig_addr, frame_start;
    logic [11:0] rv;
    int total = 0;
    int bad   = 0;

    scope_trigger_capture_if bus ();

    scope_trigger_capture dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .ch_sel      (ch_sel),
        .trig_level  (trig_level),
        .trig_edge   (trig_edge),
        .trig_auto   (trig_auto),
        .decim       (decim),
        .pre_len     (pre_len),
        .arm         (arm),
        .busy        (busy),
        .frame_ready (frame_ready),
        .triggered   (triggered),
        .trig_addr   (trig_addr),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic push(input int ch, input int val);
        @(negedge clk);
        bus.ch_data[ch*12 +: 12] = 12'(val);
        bus.ch_vld = 8'(1 << ch);
        @(negedge clk);
        bus.ch_vld = '0;
    endtask

    task automatic do_arm(input int sel, input int lvl, input logic edg, input logic aut,
                          input int dec, input int pre, input int coinc_val);
        @(negedge clk);
        ch_sel = 3'(sel); trig_level = 12'(lvl); trig_edge = edg; trig_auto = aut;
        decim = 8'(dec); pre_len = 9'(pre); arm = 1'b1;
        if (coinc_val >= 0) begin
            bus.ch_data[sel*12 +: 12] = 12'(coinc_val);
            bus.ch_vld = 8'(1 << sel);
        end
        @(negedge clk);
        arm = 1'b0;
        bus.ch_vld = '0;
    endtask

    task automatic rd(input int addr, output logic [11:0] val);
        @(negedge clk);
        bus.rd_addr = 9'(addr);
        @(negedge clk);
        val = bus.rd_data;
    endtask

    task automatic test_reset();
        bus.ch_data = '0; bus.ch_vld = '0; bus.rd_addr = '0;
        repeat (3) @(negedge clk);
        total++; if ({busy, frame_ready, triggered} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, frame_ready, triggered}); end
        total++; if (trig_addr !== 9'd0 || frame_start !== 9'd0) begin bad++; $display("FAIL reset_addr got=%0d/%0d want=0/0", trig_addr, frame_start); end
        total++; if (bus.rd_data !== 12'd0) begin bad++; $display("FAIL reset_rd_data got=%0d want=0", bus.rd_data); end
        rst_n = 1'b1;
    endtask

    task automatic test_isolation();
        do_arm(2, 2048, EDGE_RISE, 1'b0, 0, 0, -1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL iso_busy got=%b want=1", busy); end
        for (int i = 0; i < 12; i++) push((i % 3 == 0) ? 1 : ((i % 3 == 1) ? 3 : 7), (i % 2 == 1) ? 4095 : 0);
        total++; if (trig_addr !== 9'd0 || frame_start !== 9'd0) begin bad++; $display("FAIL iso_no_trig got=%0d/%0d want=0/0", trig_addr, frame_start); end
        total++; if (triggered !== 1'b0 || frame_ready !== 1'b0) begin bad++; $display("FAIL iso_flags got=%b%b want=00", triggered, frame_ready); end
        push(2, 10);
        push(2, 3000);
        total++; if (trig_addr !== 9'd1 || frame_start !== 9'd1) begin bad++; $display("FAIL iso_first_trig got=%0d/%0d want=1/1", trig_addr, frame_start); end
        total++; if (triggered !== 1'b1) begin bad++; $display("FAIL iso_triggered got=%b want=1", triggered); end
        rd(0, rv);
        total++; if (rv !== 12'd10) begin bad++; $display("FAIL iso_rd0 got=%0d want=10", rv); end
        rd(1, rv);
        total++; if (rv !== 12'd3000) begin bad++; $display("FAIL iso_rd1 got=%0d want=3000", rv); end
    endtask

    task automatic test_restart();
        do_arm(2, 500, EDGE_RISE, 1'b0, 0, 3, 4000);
        total++; if (busy !== 1'b1 || frame_ready !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b%b want=10", busy, frame_ready); end
        push(2, 100); push(2, 200); push(2, 300);
        total++; if (trig_addr !== 9'd1) begin bad++; $display("FAIL rst_pre_no_trig got=%0d want=1", trig_addr); end
        push(2, 600);
        total++; if (trig_addr !== 9'd3 || frame_start !== 9'd0) begin bad++; $display("FAIL rst_trig got=%0d/%0d want=3/0", trig_addr, frame_start); end
        total++; if (triggered !== 1'b1) begin bad++; $display("FAIL rst_triggered got=%b want=1", triggered); end
        rd(0, rv);
        total++; if (rv !== 12'd100) begin bad++; $display("FAIL rst_arm_sample_dropped got=%0d want=100", rv); end
        for (int i = 0; i < 507; i++) push(2, 700);
        total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL rst_early_done got=%b want=0", frame_ready); end
        push(2, 700);
        total++; if (frame_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rst_done got=%b%b want=10", frame_ready, busy); end
    endtask

    task automatic test_rising();
        do_arm(2, 2048, EDGE_RISE, 1'b0, 0, 100, -1);
        total++; if (frame_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rise_arm got=%b%b want=01", frame_ready, busy); end
        for (int k = 0; k < 128; k++) push(2, 16 * k);
        total++; if (trig_addr !== 9'd3) begin bad++; $display("FAIL rise_early got=%0d want=3", trig_addr); end
        push(2, 16 * 128);
        total++; if (trig_addr !== 9'd128 || frame_start !== 9'd28) begin bad++; $display("FAIL rise_trig got=%0d/%0d want=128/28", trig_addr, frame_start); end
        total++; if (triggered !== 1'b1) begin bad++; $display("FAIL rise_triggered got=%b want=1", triggered); end
        for (int k = 129; k < 539; k++) push(2, 16 * k);
        total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL rise_early_done got=%b want=0", frame_ready); end
        push(2, 16 * 539);
        total++; if (frame_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rise_done got=%b%b want=10", frame_ready, busy); end
        rd(128, rv);
        total++; if (rv !== 12'd2048) begin bad++; $display("FAIL rise_rd128 got=%0d want=2048", rv); end
        rd(28, rv);
        total++; if (rv !== 12'd448) begin bad++; $display("FAIL rise_rd28 got=%0d want=448", rv); end
        rd(27, rv);
        total++; if (rv !== 12'd432) begin bad++; $display("FAIL rise_rd27 got=%0d want=432", rv); end
    endtask

    task automatic test_falling();
        do_arm(5, 1000, EDGE_FALL, 1'b0, 3, 10, -1);
        for (int n = 0; n < 3097; n++) push(5, 4095 - n);
        total++; if (trig_addr !== 9'd262 || frame_start !== 9'd252) begin bad++; $display("FAIL fall_trig got=%0d/%0d want=262/252", trig_addr, frame_start); end
        total++; if (triggered !== 1'b1) begin bad++; $display("FAIL fall_triggered got=%b want=1", triggered); end
        for (int n = 3097; n < 5100; n++) push(5, 4095 - n);
        total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL fall_early_done got=%b want=0", frame_ready); end
        push(5, 4095 - 5100);
        total++; if (frame_ready !== 1'b1) begin bad++; $display("FAIL fall_done got=%b want=1", frame_ready); end
        rd(262, rv);
        total++; if (rv !== 12'd999) begin bad++; $display("FAIL fall_rd262 got=%0d want=999", rv); end
        rd(261, rv);
        total++; if (rv !== 12'd1003) begin bad++; $display("FAIL fall_rd261 got=%0d want=1003", rv); end
        rd(263, rv);
        total++; if (rv !== 12'd995) begin bad++; $display("FAIL fall_rd263 got=%0d want=995", rv); end
    endtask

    task automatic test_auto();
        do_arm(0, 2048, EDGE_RISE, 1'b1, 0, 500, -1);
        for (int i = 0; i < 4595; i++) push(0, 100);
        total++; if (trig_addr !== 9'd262 || triggered !== 1'b1) begin bad++; $display("FAIL auto_early got=%0d/%b want=262/1", trig_addr, triggered); end
        push(0, 100);
        total++; if (trig_addr !== 9'd499 || frame_start !== 9'd511) begin bad++; $display("FAIL auto_trig got=%0d/%0d want=499/511", trig_addr, frame_start); end
        total++; if (triggered !== 1'b0) begin bad++; $display("FAIL auto_triggered got=%b want=0", triggered); end
        for (int i = 0; i < 10; i++) push(0, 100);
        total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL auto_early_done got=%b want=0", frame_ready); end
        push(0, 100);
        total++; if (frame_ready !== 1'b1) begin bad++; $display("FAIL auto_done got=%b want=1", frame_ready); end
    endtask

    task automatic test_normal_then_reset();
        do_arm(0, 2048, EDGE_RISE, 1'b0, 0, 500, -1);
        for (int i = 0; i < 4700; i++) push(0, 100);
        total++; if (busy !== 1'b1 || frame_ready !== 1'b0) begin bad++; $display("FAIL norm_wait got=%b%b want=10", busy, frame_ready); end
        rd(5, rv);
        total++; if (rv !== 12'd100) begin bad++; $display("FAIL norm_rd5 got=%0d want=100", rv); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if ({busy, frame_ready, triggered} !== 3'b000) begin bad++; $display("FAIL arst_flags got=%b want=000", {busy, frame_ready, triggered}); end
        total++; if (trig_addr !== 9'd0 || frame_start !== 9'd0 || bus.rd_data !== 12'd0) begin bad++; $display("FAIL arst_data got=%0d/%0d/%0d want=0/0/0", trig_addr, frame_start, bus.rd_data); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) push(0, 200);
        total++; if (busy !== 1'b0 || frame_ready !== 1'b0) begin bad++; $display("FAIL idle_flags got=%b%b want=00", busy, frame_ready); end
        rd(0, rv);
        total++; if (rv !== 12'd100) begin bad++; $display("FAIL idle_no_write got=%0d want=100", rv); end
    endtask

    initial begin
        test_reset();
        test_isolation();
        test_restart();
        test_rising();
        test_falling();
        test_auto();
        test_normal_then_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
